// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the buffered UART transmitter: push strobe and data
// going in, serial line and FIFO/frame status coming back.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 trmt;
    logic [DATA_BITS-1:0] tx_data;
    logic                 TX;
    logic                 tx_done;
    logic                 busy;
    logic                 full;
    logic                 empty;
    logic                 overflow;

    modport master (
        output trmt, tx_data,
        input  TX, tx_done, busy, full, empty, overflow
    );

    modport slave (
        input  trmt, tx_data,
        output TX, tx_done, busy, full, empty, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeds a frame serializer with
// configurable data width, optional parity and one or two stop bits.
// Frames go out back-to-back while the FIFO still holds data.
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 2604,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
    localparam logic          ODD_BIT    = (PARITY_ODD != 0);
    localparam logic          HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 tx_q;
    logic                 done_q;
    logic                 ovf_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 frame_end;
    logic [DATA_BITS-1:0] head;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign push       = bus.trmt && !fifo_full;
    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign frame_end  = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    assign pop        = !fifo_empty && ((state == IDLE) || frame_end);
    assign head       = mem[rd_ptr[AW-1:0]];

    assign bus.TX       = tx_q;
    assign bus.tx_done  = done_q;
    assign bus.busy     = (state != IDLE);
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = ovf_q;

    // FIFO storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.tx_data;
        end
    end

    // Pointer bookkeeping and the overflow pulse for pushes that hit a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= bus.trmt && fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Frame serializer: each bit lasts BAUD_DIV clocks, and the word being sent
    // lives in its own shift register so later pushes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            par_bit  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= head;
                        par_bit  <= (^head) ^ ODD_BIT;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                tx_q  <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_q     <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            done_q <= 1'b1;
                            if (pop) begin
                                shreg   <= head;
                                par_bit <= (^head) ^ ODD_BIT;
                                bit_cnt <= '0;
                                tx_q    <= 1'b0;
                                state   <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four differently configured instances share clock
// and reset. A frame-timing reference model predicts every output each cycle,
// while a vector table and hand-written sequences probe specific frames.
module tb_uart_tx_fifo;

    localparam int BAUD = 16;

    typedef struct {
        int         dut;
        logic [8:0] data;
        int         len;
        logic       par;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int cfg_d     [4] = '{8, 8, 8, 7};
    int cfg_p     [4] = '{0, 1, 1, 0};
    int cfg_odd   [4] = '{0, 0, 1, 0};
    int cfg_s     [4] = '{1, 2, 2, 1};
    int cfg_depth [4] = '{4, 4, 4, 2};

    logic       trmt_v [4];
    logic [8:0] data_v [4];
    logic [5:0] outs   [4];

    int total   = 0;
    int bad     = 0;
    bit checkEn = 1'b0;

    uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if3 ();

    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(2))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.trmt    = trmt_v[0];
    assign if1.trmt    = trmt_v[1];
    assign if2.trmt    = trmt_v[2];
    assign if3.trmt    = trmt_v[3];
    assign if0.tx_data = data_v[0][7:0];
    assign if1.tx_data = data_v[1][7:0];
    assign if2.tx_data = data_v[2][7:0];
    assign if3.tx_data = data_v[3][6:0];

    // Output bundle per instance: {TX, busy, full, empty, tx_done, overflow}
    assign outs[0] = {if0.TX, if0.busy, if0.full, if0.empty, if0.tx_done, if0.overflow};
    assign outs[1] = {if1.TX, if1.busy, if1.full, if1.empty, if1.tx_done, if1.overflow};
    assign outs[2] = {if2.TX, if2.busy, if2.full, if2.empty, if2.tx_done, if2.overflow};
    assign outs[3] = {if3.TX, if3.busy, if3.full, if3.empty, if3.tx_done, if3.overflow};

    // Reference model state: a queue of accepted words plus the frame on the line,
    // tracked only as a bit vector and the number of clocks it has been sending.
    logic [8:0]  mq     [4][4];
    int          mhead  [4];
    int          mcnt   [4];
    logic [15:0] mframe [4];
    int          mel    [4];
    bit          mact   [4];
    bit          mdone  [4];
    bit          movf   [4];
    int          flen;
    bit          finishing;
    bit          doPop;
    bit          doPush;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Start bit, data LSB first, optional parity, then stop bits (upper bits stay 1).
    function automatic logic [15:0] buildFrame(input int k, input logic [8:0] d);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < cfg_d[k]; i++) begin
            f[1 + i] = d[i];
            p        = p ^ d[i];
        end
        if (cfg_p[k] != 0) begin
            f[1 + cfg_d[k]] = p ^ (cfg_odd[k] != 0);
        end
        return f;
    endfunction

    function automatic logic [5:0] expOut(input int k);
        logic txe;
        txe = mact[k] ? mframe[k][mel[k] / BAUD] : 1'b1;
        return {txe, mact[k], (mcnt[k] == cfg_depth[k]), (mcnt[k] == 0), mdone[k], movf[k]};
    endfunction

    // Model advance: the line takes a new word whenever it is free or a frame just ended.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mhead[k] = 0;
                mcnt[k]  = 0;
                mel[k]   = 0;
                mact[k]  = 1'b0;
                mdone[k] = 1'b0;
                movf[k]  = 1'b0;
                mframe[k] = '1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                flen      = (1 + cfg_d[k] + cfg_p[k] + cfg_s[k]) * BAUD;
                finishing = mact[k] && (mel[k] == flen - 1);
                doPop     = (!mact[k] || finishing) && (mcnt[k] > 0);
                doPush    = trmt_v[k] && (mcnt[k] < cfg_depth[k]);
                movf[k]   = trmt_v[k] && (mcnt[k] == cfg_depth[k]);
                mdone[k]  = finishing;
                if (doPop) begin
                    mframe[k] = buildFrame(k, mq[k][mhead[k]]);
                    mhead[k]  = (mhead[k] + 1) % cfg_depth[k];
                    mcnt[k]   = mcnt[k] - 1;
                    mel[k]    = 0;
                    mact[k]   = 1'b1;
                end else if (finishing) begin
                    mact[k] = 1'b0;
                end else if (mact[k]) begin
                    mel[k] = mel[k] + 1;
                end
                if (doPush) begin
                    mq[k][(mhead[k] + mcnt[k]) % cfg_depth[k]] = data_v[k];
                    mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("model_k%0d", k), 32'(outs[k]), 32'(expOut(k)));
            end
        end
    end

    // Pushes n words on consecutive clock edges, starting at the next edge.
    task automatic applyStimulus(input int k, input logic [8:0] d [8], input int n);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            trmt_v[k] = 1'b1;
            data_v[k] = d[i];
            @(posedge clk);
            #1;
        end
        trmt_v[k] = 1'b0;
    endtask

    task automatic waitIdle(input int k);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = (outs[k][4] == 1'b0) && (outs[k][2] == 1'b1);
        end
        checkOutput($sformatf("idle_k%0d", k), 32'(ok), 32'd1);
    endtask

    // Sends one word and decodes the line by sampling the middle of each bit.
    task automatic runVector(input vec_t v);
        logic [8:0] d [8];
        logic       line [512];
        logic [8:0] dec;
        int         lat;
        int         t;
        int         k;
        int         nb;
        k = v.dut;
        waitIdle(k);
        d = '{v.data, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        applyStimulus(k, d, 1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (outs[k][5] == 1'b1 && lat < 8);
        checkOutput($sformatf("latency_k%0d_%0h", k, v.data), lat, 2);
        t = 0;
        line[0] = outs[k][5];
        while (outs[k][1] == 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
            line[t] = outs[k][5];
        end
        checkOutput($sformatf("length_k%0d_%0h", k, v.data), t, v.len);
        dec = '0;
        for (int i = 0; i < cfg_d[k]; i++) begin
            dec[i] = line[(1 + i) * BAUD + 8];
        end
        checkOutput($sformatf("data_k%0d_%0h", k, v.data), 32'(dec), 32'(v.data));
        if (cfg_p[k] != 0) begin
            checkOutput($sformatf("parity_k%0d_%0h", k, v.data),
                        32'(line[(1 + cfg_d[k]) * BAUD + 8]), 32'(v.par));
        end
        nb = 1 + cfg_d[k] + cfg_p[k] + cfg_s[k];
        checkOutput($sformatf("stop_k%0d_%0h", k, v.data), 32'(line[(nb - 1) * BAUD + 8]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [9];
        logic [8:0] d [8];
        int         doneCnt;
        int         busyLow;
        int         ovfCnt;
        int         doneIdx [3];
        logic       emptyAtDone [3];
        vec_t       post;
        int         rate;

        for (int k = 0; k < 4; k++) begin
            trmt_v[k] = 1'b0;
            data_v[k] = '0;
        end

        vecs[0] = '{0, 9'h0A5, 160, 1'b0};
        vecs[1] = '{0, 9'h03C, 160, 1'b0};
        vecs[2] = '{1, 9'h007, 192, 1'b1};
        vecs[3] = '{2, 9'h007, 192, 1'b0};
        vecs[4] = '{1, 9'h000, 192, 1'b0};
        vecs[5] = '{2, 9'h000, 192, 1'b1};
        vecs[6] = '{2, 9'h0FF, 192, 1'b1};
        vecs[7] = '{3, 9'h041, 144, 1'b0};
        vecs[8] = '{3, 9'h07F, 144, 1'b0};

        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("reset_k%0d", k), 32'(outs[k]), 32'(6'b100100));
        end
        rst_n   = 1'b1;
        checkEn = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) begin
            runVector(vecs[i]);
        end

        $display("[TB] back-to-back frames");
        waitIdle(0);
        d = '{9'h055, 9'h0AA, 9'h00F, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        applyStimulus(0, d, 3);
        doneCnt = 0;
        busyLow = 0;
        for (int c = 1; c <= 700 && doneCnt < 3; c++) begin
            @(negedge clk);
            if (outs[0][4] == 1'b0 && outs[0][1] == 1'b0) busyLow++;
            if (outs[0][1] == 1'b1) begin
                doneIdx[doneCnt]     = c;
                emptyAtDone[doneCnt] = outs[0][2];
                doneCnt++;
            end
        end
        checkOutput("b2b_done_count", doneCnt, 3);
        checkOutput("b2b_busy_gap", busyLow, 0);
        if (doneCnt == 3) begin
            checkOutput("b2b_first_done", doneIdx[0], 160);
            checkOutput("b2b_gap1", doneIdx[1] - doneIdx[0], 160);
            checkOutput("b2b_gap2", doneIdx[2] - doneIdx[1], 160);
            checkOutput("b2b_empty_at_done1", 32'(emptyAtDone[0]), 32'd0);
            checkOutput("b2b_empty_at_done2", 32'(emptyAtDone[1]), 32'd1);
        end

        $display("[TB] overflow burst");
        waitIdle(0);
        d = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, 9'h0, 9'h0};
        applyStimulus(0, d, 6);
        @(negedge clk);
        checkOutput("ovf_pulse", 32'(outs[0][0]), 32'd1);
        checkOutput("full_after_burst", 32'(outs[0][3]), 32'd1);
        ovfCnt  = 1;
        doneCnt = 0;
        for (int c = 2; c <= 900; c++) begin
            @(negedge clk);
            if (outs[0][0] == 1'b1) ovfCnt++;
            if (outs[0][1] == 1'b1) doneCnt++;
        end
        checkOutput("ovf_count", ovfCnt, 1);
        checkOutput("ovf_frames_sent", doneCnt, 5);

        $display("[TB] reset mid-frame");
        waitIdle(0);
        d = '{9'h0C3, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
        applyStimulus(0, d, 1);
        repeat (57) @(negedge clk);
        checkOutput("tx_low_before_reset", 32'(outs[0][5]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("async_reset_k%0d", k), 32'(outs[k]), 32'(6'b100100));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        post  = '{0, 9'h096, 160, 1'b0};
        runVector(post);

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            rate = (cyc < 1500) ? 15 : 250;
            for (int k = 0; k < 4; k++) begin
                trmt_v[k] = ($urandom_range(rate) == 0);
                data_v[k] = 9'($urandom);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            trmt_v[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            waitIdle(k);
        end

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It adds configurable data width, optional parity, one or two stop bits, and a small transmit FIFO so the producer can queue bytes without polling. It sits between the command/telemetry logic and the TX pin of the serial link. Frames are sent back-to-back while the FIFO holds data.

Parameters:
BAUD_DIV, 2604, clocks per bit period (≥ 4); each bit is held exactly BAUD_DIV clocks
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, FIFO entries (power of 2, ≥ 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trmt  input  1  push strobe: write tx_data into FIFO this cycle
tx_data  input  DATA_BITS  byte to queue
TX  output  1  serial line, idle high
tx_done  output  1  one-cycle pulse when a frame's final stop bit completes
busy  output  1  high while a frame is on the line (state ≠ IDLE)
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
overflow  output  1  one-cycle pulse when trmt is asserted while full (data dropped)

Behaviour:
- Reset (async, rst_n low): FIFO empty, pointers 0, state IDLE, TX = 1, tx_done = 0, busy = 0, full = 0, empty = 1, overflow = 0. Reset mid-frame aborts immediately; TX returns high with no glitch low.
- Push: trmt && !full writes tx_data at the cycle's clock edge. trmt && full drops the data and pulses overflow on the next cycle. A push while full is rejected even if a pop occurs in the same cycle.
- Pop: happens only in the frame-load cycle. Simultaneous push and pop with 0 < count < FIFO_DEPTH leaves the count unchanged.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when !empty: pop into the shift register and drive TX = 0.
- Latency: with trmt at edge N into an empty FIFO in IDLE, empty falls after edge N, the load occurs at edge N+1, and TX goes low after edge N+1.
- START: hold TX = 0 for BAUD_DIV clocks, then → DATA.
- DATA: shift out DATA_BITS bits LSB first, each BAUD_DIV clocks. Then → PARITY if PARITY_EN, else → STOP.
- PARITY: TX = XOR of data bits (even), inverted if PARITY_ODD. Hold BAUD_DIV clocks, then → STOP.
- STOP: TX = 1 for STOP_BITS × BAUD_DIV clocks. At the end, pulse tx_done for 1 cycle.
  - If !empty: pop and go directly to START, with no idle gap (the next TX low starts the cycle after the last stop clock).
  - Else → IDLE.
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) × BAUD_DIV clocks exactly.
- Baud counter width: $clog2(BAUD_DIV). It clears on load and on each bit boundary and never wraps mid-bit.
- Bit counter: $clog2(DATA_BITS+1) bits wide.
- The data being transmitted is held in the shift register, independent of the FIFO. Pushes during a frame never corrupt the frame in flight.
- busy is high from the load cycle through the last stop clock. It stays high across back-to-back frames.
- FIFO pointers use an extra wrap bit: full = MSBs differ and the rest are equal; empty = pointers equal. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- BAUD_DIV=16, defaults, push 8'hA5 → TX low 2 clocks after trmt; bits 1,0,1,0,0,1,0,1 then stop, each 16 clocks; tx_done pulses once at clock 160 of the frame.
- Push 8'h55, 8'hAA, 8'h0F in consecutive cycles → three contiguous 160-clock frames with no idle gap; busy stays high throughout; tx_done pulses 3 times; empty is reached after the third load.
- FIFO_DEPTH=4, push 6 bytes in consecutive cycles while idle → first byte popped, 4 queued, full asserted; 6th push pulses overflow; only 5 frames are transmitted.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 8'h07 → parity bit 1, two stop bits, frame is 12×16 = 192 clocks; with PARITY_ODD=1 the parity bit is 0.
- DATA_BITS=7, send 7'h41 → 9-bit frame of 144 clocks; upper bit not driven.
- rst_n low mid-DATA bit → TX = 1, busy = 0, empty = 1 asynchronously; after release, a new push transmits correctly.
